// File: rtl/clock_sim_pkg.sv
// Shared types and constants for the clock simulator time-keeping blocks.
package clock_sim_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SET_HOUR = 2'd1,
        SET_MIN  = 2'd2
    } time_state_t;

    localparam int SEC_MAX    = 59;
    localparam int MIN_MAX    = 59;
    localparam int HOUR24_MAX = 23;
    localparam int HOUR12_MAX = 12;

    localparam int SEC_W  = 6;
    localparam int MIN_W  = 6;
    localparam int HOUR_W = 5;

endpackage

// File: rtl/clock_time_counter_mod_counter.sv
// Wrapping modulo counter 0..MAX; wrap is the combinational carry out.
module mod_counter #(
    parameter int WIDTH = 6,
    parameter int MAX   = 59
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] count,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

    assign wrap = inc && (count == MAX_V);

    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (inc) begin
            count <= wrap ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/clock_time_counter.sv
// Time-of-day counter driven by the divider toggle output, with button set mode.
// Define CLOCK_12H_EN for a 12-hour display with AM/PM flag; default is 24-hour.
module clock_time_counter
    import clock_sim_pkg::*;
#(
    parameter int EDGES_PER_SEC = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              tick_in,
    input  logic              mode_btn,
    input  logic              inc_btn,
    output logic [HOUR_W-1:0] hours,
    output logic [MIN_W-1:0]  minutes,
    output logic [SEC_W-1:0]  seconds,
    output logic              pm,
    output logic [1:0]        state,
    output logic              second_pulse
);

    localparam logic [7:0] EDGE_TOP = 8'(EDGES_PER_SEC - 1);

    time_state_t state_q, state_d;
    logic        tick_q;
    logic [7:0]  edge_cnt;
    logic        tick_rise, sec_strobe, in_run, field_inc;
    logic        sec_inc, sec_wrap, sec_clear, min_inc, min_wrap, hour_inc;

    assign tick_rise  = tick_in & ~tick_q;
    assign sec_strobe = tick_rise && (edge_cnt == EDGE_TOP);
    assign in_run     = (state_q == RUN);
    // A mode press wins over a simultaneous increment press.
    assign field_inc  = inc_btn & ~mode_btn;
    assign sec_inc    = in_run & sec_strobe;
    assign sec_clear  = (state_q == SET_MIN) & mode_btn;
    assign min_inc    = in_run ? sec_wrap : ((state_q == SET_MIN) & field_inc);
    assign hour_inc   = in_run ? min_wrap : ((state_q == SET_HOUR) & field_inc);

    // tick_q resets high to match the divider so no false edge follows reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            tick_q   <= 1'b1;
            edge_cnt <= 8'd0;
        end else begin
            tick_q <= tick_in;
            if (!in_run) begin
                edge_cnt <= 8'd0;
            end else if (tick_rise) begin
                edge_cnt <= sec_strobe ? 8'd0 : edge_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= RUN;
            second_pulse <= 1'b0;
        end else begin
            state_q      <= state_d;
            second_pulse <= sec_inc;
        end
    end

    always_comb begin
        state_d = state_q;
        if (mode_btn) begin
            case (state_q)
                RUN:      state_d = SET_HOUR;
                SET_HOUR: state_d = SET_MIN;
                SET_MIN:  state_d = RUN;
                default:  state_d = RUN;
            endcase
        end
    end

    assign state = state_q;

    mod_counter #(.WIDTH(SEC_W), .MAX(SEC_MAX)) u_seconds (
        .clock (clock),
        .reset (reset | sec_clear),
        .inc   (sec_inc),
        .count (seconds),
        .wrap  (sec_wrap)
    );

    mod_counter #(.WIDTH(MIN_W), .MAX(MIN_MAX)) u_minutes (
        .clock (clock),
        .reset (reset),
        .inc   (min_inc),
        .count (minutes),
        .wrap  (min_wrap)
    );

`ifdef CLOCK_12H_EN
    localparam logic [HOUR_W-1:0] HOUR_TOP = HOUR_W'(HOUR12_MAX);
    localparam logic [HOUR_W-1:0] HOUR_PRE = HOUR_W'(HOUR12_MAX - 1);

    // 11 -> 12 flips AM/PM; 12 -> 1 does not.
    always_ff @(posedge clock) begin
        if (reset) begin
            hours <= HOUR_TOP;
            pm    <= 1'b0;
        end else if (hour_inc) begin
            hours <= (hours == HOUR_TOP) ? HOUR_W'(1) : hours + 1'b1;
            if (hours == HOUR_PRE) begin
                pm <= ~pm;
            end
        end
    end
`else
    localparam logic [HOUR_W-1:0] HOUR_TOP = HOUR_W'(HOUR24_MAX);

    always_ff @(posedge clock) begin
        if (reset) begin
            hours <= '0;
        end else if (hour_inc) begin
            hours <= (hours == HOUR_TOP) ? '0 : hours + 1'b1;
        end
    end

    assign pm = 1'b0;
`endif

endmodule
